// File: rtl/apbdma_apb_backend_if.sv
// apbdma_apb_backend_if
//   Bundles the command, write-beat, read-beat, APB4 and status signals of the
//   APB DMA backend into one interface.
//   Modports:
//     master : the backend itself. It takes commands and beats in, and drives
//              the APB request and the status outputs.
//     slave  : the surroundings (midend plus APB completer). This is the
//              mirror image of master.
//   Signal groups:
//     cmd_*   command handshake (addr, len = beats-1, write)
//     w_*     write beat from the midend
//     r_*     read beat to the midend
//     p*      APB4 request/completion
//     done_o / err_o  command completion pulse and its error status
interface apbdma_apb_backend_if #(
  parameter int AddrWidth = 32,
  parameter int DataWidth = 32,
  parameter int LenWidth  = 8
);
  logic                   cmd_valid_i;
  logic                   cmd_ready_o;
  logic [AddrWidth-1:0]   cmd_addr_i;
  logic [LenWidth-1:0]    cmd_len_i;
  logic                   cmd_write_i;

  logic [DataWidth-1:0]   w_data_i;
  logic [DataWidth/8-1:0] w_strb_i;
  logic                   w_valid_i;
  logic                   w_ready_o;

  logic [DataWidth-1:0]   r_data_o;
  logic                   r_valid_o;
  logic                   r_ready_i;

  logic [AddrWidth-1:0]   paddr_o;
  logic                   psel_o;
  logic                   penable_o;
  logic                   pwrite_o;
  logic [DataWidth-1:0]   pwdata_o;
  logic [DataWidth/8-1:0] pstrb_o;
  logic                   pready_i;
  logic [DataWidth-1:0]   prdata_i;
  logic                   pslverr_i;

  logic                   done_o;
  logic                   err_o;

  modport master (
    input  cmd_valid_i, cmd_addr_i, cmd_len_i, cmd_write_i,
    input  w_data_i, w_strb_i, w_valid_i,
    input  r_ready_i,
    input  pready_i, prdata_i, pslverr_i,
    output cmd_ready_o, w_ready_o, r_data_o, r_valid_o,
    output paddr_o, psel_o, penable_o, pwrite_o, pwdata_o, pstrb_o,
    output done_o, err_o
  );

  modport slave (
    output cmd_valid_i, cmd_addr_i, cmd_len_i, cmd_write_i,
    output w_data_i, w_strb_i, w_valid_i,
    output r_ready_i,
    output pready_i, prdata_i, pslverr_i,
    input  cmd_ready_o, w_ready_o, r_data_o, r_valid_o,
    input  paddr_o, psel_o, penable_o, pwrite_o, pwdata_o, pstrb_o,
    input  done_o, err_o
  );
endinterface

// File: rtl/apbdma_apb_backend.sv
// apbdma_apb_backend
//   APB4 backend of a DMA engine. It accepts one command (start address,
//   beat count minus one, direction). It then runs one APB transfer per beat:
//     - for writes, it consumes one midend beat per APB write;
//     - for reads, it produces one midend beat per APB read.
//   At the end it pulses done_o, with err_o carrying the sticky OR of pslverr.
//   Ports:
//     clk_i  single clock, all logic on the rising edge
//     rst_i  synchronous, active-high reset
//     bus    apbdma_apb_backend_if.master. It carries the cmd / w / r
//            handshakes, the APB4 request/completion and done/err.
//   Optional feature (macro APBDMA_BACKEND_TIMEOUT_EN):
//     When the macro is defined, an ACCESS phase that sees no pready_i for
//     256 cycles completes as an error beat (read data 0). Without the macro,
//     ACCESS waits for pready_i forever.
module apbdma_apb_backend #(
  parameter int AddrWidth = 32,
  parameter int DataWidth = 32,
  parameter int LenWidth  = 8
) (
  input logic                   clk_i,
  input logic                   rst_i,
  apbdma_apb_backend_if.master  bus
);

  localparam int unsigned Bytes = DataWidth / 8;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_W,
    SETUP,
    ACCESS,
    R_HOLD
  } state_t;

  state_t              state;
  logic [LenWidth-1:0] beat_cnt;
  logic                err_flag;
  logic                beat_end;
  logic                beat_err;
  logic                to_hit;

  function automatic logic [AddrWidth-1:0] next_addr(input logic [AddrWidth-1:0] a);
    // Natural wrap modulo 2^AddrWidth.
    return a + AddrWidth'(Bytes);
  endfunction

`ifdef APBDMA_BACKEND_TIMEOUT_EN
  logic [7:0] to_cnt;
  // The 256th ACCESS cycle without pready counts as an error completion.
  assign to_hit = (state == ACCESS) && !bus.pready_i && (to_cnt == 8'hFF);
`else
  assign to_hit = 1'b0;
`endif

  assign beat_end = (state == ACCESS) && (bus.pready_i || to_hit);
  // A timeout forces the error; otherwise the completer's pslverr decides.
  assign beat_err = to_hit ? 1'b1 : bus.pslverr_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state         <= IDLE;
      beat_cnt      <= '0;
      err_flag      <= 1'b0;
      bus.cmd_ready_o <= 1'b1;
      bus.w_ready_o <= 1'b0;
      bus.r_valid_o <= 1'b0;
      bus.r_data_o  <= '0;
      bus.psel_o    <= 1'b0;
      bus.penable_o <= 1'b0;
      bus.pwrite_o  <= 1'b0;
      bus.paddr_o   <= '0;
      bus.pwdata_o  <= '0;
      bus.pstrb_o   <= '0;
      bus.done_o    <= 1'b0;
      bus.err_o     <= 1'b0;
`ifdef APBDMA_BACKEND_TIMEOUT_EN
      to_cnt        <= '0;
`endif
    end else begin
      bus.done_o <= 1'b0;
      bus.err_o  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.cmd_valid_i && bus.cmd_ready_o) begin
            bus.paddr_o     <= bus.cmd_addr_i;
            bus.pwrite_o    <= bus.cmd_write_i;
            beat_cnt        <= bus.cmd_len_i;
            err_flag        <= 1'b0;
            bus.cmd_ready_o <= 1'b0;
            if (bus.cmd_write_i) begin
              bus.w_ready_o <= 1'b1;
              state         <= WAIT_W;
            end else begin
              // Reads never present write data or strobes on the bus.
              bus.pwdata_o  <= '0;
              bus.pstrb_o   <= '0;
              bus.psel_o    <= 1'b1;
              state         <= SETUP;
            end
          end
        end

        WAIT_W: begin
          if (bus.w_valid_i) begin
            bus.pwdata_o  <= bus.w_data_i;
            bus.pstrb_o   <= bus.w_strb_i;
            bus.w_ready_o <= 1'b0;
            bus.psel_o    <= 1'b1;
            state         <= SETUP;
          end
        end

        SETUP: begin
          bus.penable_o <= 1'b1;
          state         <= ACCESS;
`ifdef APBDMA_BACKEND_TIMEOUT_EN
          to_cnt        <= '0;
`endif
        end

        ACCESS: begin
`ifdef APBDMA_BACKEND_TIMEOUT_EN
          if (!beat_end) to_cnt <= to_cnt + 8'd1;
`endif
          if (beat_end) begin
            bus.psel_o    <= 1'b0;
            bus.penable_o <= 1'b0;
            err_flag      <= err_flag | beat_err;
            if (bus.pwrite_o) begin
              if (beat_cnt == '0) begin
                bus.done_o      <= 1'b1;
                bus.err_o       <= err_flag | beat_err;
                bus.cmd_ready_o <= 1'b1;
                state           <= IDLE;
              end else begin
                bus.paddr_o   <= next_addr(bus.paddr_o);
                beat_cnt      <= beat_cnt - LenWidth'(1);
                bus.w_ready_o <= 1'b1;
                state         <= WAIT_W;
              end
            end else begin
              bus.r_data_o  <= beat_err ? '0 : bus.prdata_i;
              bus.r_valid_o <= 1'b1;
              state         <= R_HOLD;
            end
          end
        end

        R_HOLD: begin
          if (bus.r_ready_i) begin
            bus.r_valid_o <= 1'b0;
            if (beat_cnt == '0) begin
              bus.done_o      <= 1'b1;
              bus.err_o       <= err_flag;
              bus.cmd_ready_o <= 1'b1;
              state           <= IDLE;
            end else begin
              bus.paddr_o <= next_addr(bus.paddr_o);
              beat_cnt    <= beat_cnt - LenWidth'(1);
              bus.psel_o  <= 1'b1;
              state       <= SETUP;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
